// File: rtl/dacx311_feeder_pkg.sv
// Shared types and constants for the DACx311 sample feeder.
package dacx311_feeder_pkg;

  localparam int DAC_BITS   = 12;
  localparam int UNDERRUN_W = 16;

  // Power-down field encodings as the DACx311 expects them
  localparam logic [1:0] PD_NORMAL = 2'd0;
  localparam logic [1:0] PD_1K     = 2'd1;
  localparam logic [1:0] PD_100K   = 2'd2;
  localparam logic [1:0] PD_HIZ    = 2'd3;

  typedef logic [DAC_BITS-1:0]   dac_code_t;
  typedef logic [1:0]            pd_t;
  typedef logic [UNDERRUN_W-1:0] underrun_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic underrun_t sat_inc(input underrun_t v);
    return (v == '1) ? v : underrun_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/dacx311_feeder_sync_fifo.sv
// Single-clock FIFO with registered occupancy and synchronous flush.
// The head is a plain read of the storage at rd_ptr, so a pushed word
// becomes visible at the head on the cycle after it is written.
module sync_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  output logic                  push_ready,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  not_empty,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Flush swallows any push or pop presented on the same edge
  assign push_ready = (level < FULL_LVL);
  assign not_empty  = (level != '0);
  assign do_push    = push && push_ready && !flush;
  assign do_pop     = pop && not_empty && !flush;
  assign head       = mem[rd_ptr];

  // Storage write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (do_push && !reset)
      mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo depth; level carries the extra bit for full
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dacx311_feeder.sv
// Sample buffer in front of the DACx311 SPI driver. Samples queue in a
// small FIFO; the DAC word and power-down field are only updated on the
// end-of-frame pulse so they hold steady for the whole next SPI frame.
module dacx311_feeder
  import dacx311_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  selected,
  input  logic                  ready,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DAC_BITS-1:0]   in_data,
  input  logic [1:0]            pd_req,
  output logic [DAC_BITS-1:0]   data_out,
  output logic [1:0]            pd_out,
  output logic [DEPTH_LOG2:0]   level,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  dac_code_t head;
  logic      not_empty;
  logic      take;
  logic      starve;
  logic      sel_unused;

  // The frame boundary is the ready pulse alone; a ready arriving with
  // slave select already dropped is still a boundary, so select is not used.
  assign sel_unused = selected;

  assign take   = ready && !flush && not_empty;
  assign starve = ready && !flush && !not_empty;

  sync_fifo #(
    .WIDTH      (DAC_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (in_valid),
    .push_ready (in_ready),
    .push_data  (in_data),
    .pop        (ready),
    .not_empty  (not_empty),
    .head       (head),
    .level      (level)
  );

  // Frame-boundary latch: power-down follows the request every frame,
  // data only advances when a sample is actually waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      pd_out   <= PD_HIZ;
    end else if (ready) begin
      pd_out <= pd_req;
      if (take) data_out <= head;
    end
  end

  // Count frames that found the FIFO empty; flushed frames are not starved
  always_ff @(posedge clk) begin
    if (reset)
      underrun_cnt <= '0;
    else if (starve)
      underrun_cnt <= sat_inc(underrun_cnt);
  end

endmodule

// File: tb/tb_dacx311_feeder.sv
// Directed bench for dacx311_feeder. Frame results are queued as expected
// before each ready pulse and checked by a monitor after every ready edge.
module tb_dacx311_feeder;
  import dacx311_feeder_pkg::*;

  logic        clk = 0;
  logic        reset = 1;
  logic        selected = 0;
  logic        ready = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic [1:0]  pd_req = PD_NORMAL;
  logic [11:0] data_out;
  logic [1:0]  pd_out;
  logic [2:0]  level;
  logic [15:0] underrun_cnt;

  typedef struct {
    logic [11:0] d;
    logic [1:0]  p;
    logic [15:0] u;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  dacx311_feeder #(.DEPTH_LOG2(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .selected     (selected),
    .ready        (ready),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .pd_req       (pd_req),
    .data_out     (data_out),
    .pd_out       (pd_out),
    .level        (level),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every ready edge is a frame result; compare against the queue
  always @(posedge clk) begin
    if (ready && !reset) begin
      #1;
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", int'(data_out), int'(e.d));
        check("frame_pd", int'(pd_out), int'(e.p));
        check("frame_underrun", int'(underrun_cnt), int'(e.u));
      end
    end
  end

  task automatic push(input logic [11:0] d);
    in_valid = 1; in_data = d;
    @(negedge clk);
    in_valid = 0;
  endtask

  // One SPI frame: select high, then a single-cycle ready pulse
  task automatic frame(input logic [11:0] d, input logic [1:0] p,
                       input logic [15:0] u, input logic sel);
    selected = 1;
    repeat (14) @(negedge clk);
    selected = sel;
    ready = 1;
    exp_q.push_back('{d, p, u});
    @(negedge clk);
    ready = 0;
    selected = 0;
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    check("rst_data", int'(data_out), 0);
    check("rst_pd", int'(pd_out), 3);
    check("rst_level", int'(level), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_underrun", int'(underrun_cnt), 0);

    // Two samples, one per frame, data held between boundaries
    pd_req = PD_NORMAL;
    push(12'h123);
    push(12'h456);
    check("two_level", int'(level), 2);
    frame(12'h123, PD_NORMAL, 16'd0, 1'b1);
    repeat (8) @(negedge clk);
    check("hold_mid_frame", int'(data_out), 12'h123);
    frame(12'h456, PD_NORMAL, 16'd0, 1'b1);
    check("drained_level", int'(level), 0);

    // Fill past depth with valid held
    push(12'h001); push(12'h002); push(12'h003); push(12'h004);
    in_valid = 1; in_data = 12'h005;
    @(negedge clk);
    check("full_in_ready", int'(in_ready), 0);
    check("full_level", int'(level), 4);
    ready = 1;
    exp_q.push_back('{12'h001, PD_NORMAL, 16'd0});
    @(negedge clk);
    ready = 0;
    check("freed_in_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    check("fifth_level", int'(level), 4);
    frame(12'h002, PD_NORMAL, 16'd0, 1'b1);
    frame(12'h003, PD_NORMAL, 16'd0, 1'b1);
    frame(12'h004, PD_NORMAL, 16'd0, 1'b1);
    frame(12'h005, PD_NORMAL, 16'd0, 1'b1);

    // Underruns hold the last value; one boundary arrives with select low
    push(12'h7FF);
    frame(12'h7FF, PD_NORMAL, 16'd0, 1'b1);
    frame(12'h7FF, PD_NORMAL, 16'd1, 1'b1);
    frame(12'h7FF, PD_NORMAL, 16'd2, 1'b0);
    frame(12'h7FF, PD_NORMAL, 16'd3, 1'b1);
    in_valid = 1; in_data = 12'h2AA; ready = 1;
    exp_q.push_back('{12'h7FF, PD_NORMAL, 16'd4});
    @(negedge clk);
    in_valid = 0; ready = 0;
    check("push_on_underrun_level", int'(level), 1);
    frame(12'h2AA, PD_NORMAL, 16'd4, 1'b1);

    // Flush coincident with ready
    pd_req = PD_100K;
    push(12'h111); push(12'h222); push(12'h333);
    check("preflush_level", int'(level), 3);
    flush = 1; ready = 1;
    exp_q.push_back('{12'h2AA, PD_100K, 16'd4});
    @(negedge clk);
    flush = 0; ready = 0;
    check("flush_level", int'(level), 0);
    check("flush_in_ready", int'(in_ready), 1);
    frame(12'h2AA, PD_100K, 16'd5, 1'b1);

    // Reset in the middle of a frame
    push(12'h0AA); push(12'h0BB);
    selected = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    selected = 0;
    check("mid_rst_data", int'(data_out), 0);
    check("mid_rst_pd", int'(pd_out), 3);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_underrun", int'(underrun_cnt), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    push(12'hABC);
    frame(12'hABC, PD_100K, 16'd0, 1'b1);

    // Let the monitor consume the last expectation, bounded
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dacx311_feeder.md
Name: dacx311_feeder

Overview:
- Sample-buffering stage directly upstream of the DACx311 SPI driver; supplies its 12-bit data word and 2-bit power-down field.
- Accepts samples through a valid/ready stream into a small FIFO.
- Updates data_out/pd_out only on the end-of-frame pulse, so they stay stable for the whole SPI frame.
- Holds the last value and counts underruns when no sample is available.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth (depth = 4 by default; legal range 1..6).

Ports:
- clk  input  1  bit clock; same clock as the SPI driver and controller.
- reset  input  1  synchronous reset, active-high.
- selected  input  1  non-inverted slave select from the SPI master controller; high during a frame.
- ready  input  1  end-of-frame pulse from the SPI master controller; high for exactly one clk.
- flush  input  1  synchronous FIFO clear; does not alter data_out/pd_out.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  FIFO can accept a sample.
- in_data  input  12  upstream DAC code.
- pd_req  input  2  requested power-down mode: 0 normal, 1 1k to gnd, 2 100k, 3 high-Z.
- data_out  output  12  DAC code to the driver.
- pd_out  output  2  power-down field to the driver.
- level  output  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2.
- underrun_cnt  output  16  saturating count of frames with an empty FIFO.

Behaviour:
- Reset values (all outputs registered, cleared on the edge with reset=1):
  - data_out=0, pd_out=3 (high-Z until the first frame boundary).
  - level=0, underrun_cnt=0, FIFO pointers=0.
  - in_ready=1 from the first cycle after reset.
- Priority: reset > flush > normal operation.
- Reset mid-frame discards all FIFO contents. It does not affect selected/ready interpretation on later cycles.
- Push:
  - Occurs when in_valid && in_ready on a clk edge.
  - in_ready = (level < 2^DEPTH_LOG2), combinational from the registered level.
  - No bypass: a pushed sample is visible at the head one cycle later.
- Pop (frame boundary), on an edge where ready=1:
  - FIFO non-empty (level>0 before the edge): data_out <= head, pointer advances, level decrements.
  - FIFO empty: data_out holds; underrun_cnt increments, saturating at 16'hFFFF.
  - pd_out <= pd_req on every ready edge, independent of FIFO state.
- Stability:
  - data_out/pd_out change only on a ready edge, so they are stable from one frame end to the next.
  - selected is not used for timing. It feeds one check only: a ready pulse with selected=0 is still treated as a frame boundary.
- Simultaneous push and pop:
  - level unchanged; both pointers advance.
  - When full, in_ready=0, so no push occurs; the pop frees a slot visible the next cycle.
  - When empty, the push lands, the pop underruns (counted), and data_out holds.
- flush=1:
  - Pointers and level go to 0. Any concurrent push or pop is discarded.
  - A concurrent ready still latches pd_out.
  - A concurrent ready with flush does not count as an underrun.
- Wrap-around: pointers are DEPTH_LOG2 bits wide and wrap modulo depth. level is tracked separately with one extra bit.

Decomposition:
- Shared package:
  - DAC_BITS=12.
  - PD_NORMAL=0, PD_1K=1, PD_100K=2, PD_HIZ=3.
  - UNDERRUN_W=16.
- One natural sub-module: sync_fifo (single-clock, parameterised width/depth, registered level, push/pop/flush). The feeder wraps it with the frame-boundary latch and the underrun counter.

Test Plan:
- Reset, then 3 idle clks -> data_out=0, pd_out=3, level=0, in_ready=1, underrun_cnt=0.
- Push 0x123, 0x456 with pd_req=0; ready pulse every 16 clks -> first ready: data_out=0x123, pd_out=0; second ready: data_out=0x456; data_out constant between pulses.
- Push 5 samples into a depth-4 FIFO with in_valid held -> 4 accepted, in_ready=0, level=4; after one ready, in_ready=1 next cycle and the 5th sample is accepted.
- Empty FIFO, three ready pulses with a last value of 0x7FF -> data_out stays 0x7FF, underrun_cnt=3. Push and ready in the same cycle -> underrun_cnt=4, and the sample appears at the next ready.
- Load 3 samples, assert flush coincident with ready and pd_req=2 -> level=0, data_out unchanged, pd_out=2, underrun_cnt unchanged.
- Load 2 samples, assert reset mid-frame -> all outputs return to reset values; next push 0xABC plus ready -> data_out=0xABC.
